// File: rtl/rf_issue_arbiter.sv
// rf_issue_arbiter: picks one ready head entry per cycle from the issue
// queue (IQ) or the load/store queue (LSQ) and registers it for the
// register-file stage. IQ has fixed priority over the LSQ.
// Optional feature: define ARB_AGE_LIMIT_EN to add LSQ anti-starvation.
// The LSQ is then forced through after AGE_LIMIT consecutive losses to the IQ.
module rf_issue_arbiter #(
    parameter int RENISS_WIDTH = 137,
    parameter int AGE_LIMIT    = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    FREEZE,
    input  logic                    FLUSH,
    input  logic                    IQ_empty,
    input  logic                    IQ_headRdy,
    input  logic [RENISS_WIDTH-1:0] IQ_popData,
    output logic                    IQ_pop,
    input  logic                    LSQ_empty,
    input  logic                    LSQ_headRdy,
    input  logic [RENISS_WIDTH-1:0] LSQ_popData,
    output logic                    LSQ_pop,
    output logic [RENISS_WIDTH-1:0] IQLSQ_popData_OUT,
    output logic                    Valid_Instruction_OUT,
    output logic                    Mem_Instruction_OUT
);

    logic                    w_elig_iq;
    logic                    w_elig_lsq;
    logic                    w_pop_en;
    logic                    w_force_lsq;
    logic                    w_grant_iq;
    logic                    w_grant_lsq;

    logic [RENISS_WIDTH-1:0] r_data;
    logic                    r_valid;
    logic                    r_mem;

    assign w_elig_iq  = !IQ_empty  && IQ_headRdy;
    assign w_elig_lsq = !LSQ_empty && LSQ_headRdy;

    // Pops are suppressed while reset is held so nothing leaves a queue
    // that the output register cannot capture.
    assign w_pop_en = RESET && !FREEZE && !FLUSH;

`ifdef ARB_AGE_LIMIT_EN
    localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

    logic [3:0] r_age;

    assign w_force_lsq = (r_age == AGE_MAX) && w_elig_lsq;

    // Count consecutive IQ wins over a waiting LSQ; cleared on LSQ win or flush.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_age <= 4'd0;
        end else if (FLUSH) begin
            r_age <= 4'd0;
        end else if (!FREEZE) begin
            if (w_grant_lsq) begin
                r_age <= 4'd0;
            end else if (w_grant_iq && w_elig_lsq && (r_age != AGE_MAX)) begin
                r_age <= r_age + 4'd1;
            end
        end
    end
`else
    assign w_force_lsq = 1'b0;
`endif

    // Grant select: IQ first unless the LSQ is alone or being forced through.
    always_comb begin
        w_grant_lsq = w_elig_lsq && (!w_elig_iq || w_force_lsq);
        w_grant_iq  = w_elig_iq && !w_grant_lsq;
    end

    assign IQ_pop  = w_pop_en && w_grant_iq;
    assign LSQ_pop = w_pop_en && w_grant_lsq;

    // Output register: capture the granted entry, bubble when nothing wins.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_mem   <= 1'b0;
        end else if (FLUSH) begin
            r_valid <= 1'b0;
            r_mem   <= 1'b0;
        end else if (!FREEZE) begin
            if (w_grant_lsq) begin
                r_data  <= LSQ_popData;
                r_valid <= 1'b1;
                r_mem   <= 1'b1;
            end else if (w_grant_iq) begin
                r_data  <= IQ_popData;
                r_valid <= 1'b1;
                r_mem   <= 1'b0;
            end else begin
                r_valid <= 1'b0;
                r_mem   <= 1'b0;
            end
        end
    end

    assign IQLSQ_popData_OUT     = r_data;
    assign Valid_Instruction_OUT = r_valid;
    assign Mem_Instruction_OUT   = r_mem;

endmodule

// File: tb/tb_rf_issue_arbiter.sv
// Testbench for rf_issue_arbiter: vector table, directed corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_rf_issue_arbiter;

    localparam int W     = 137;
    localparam int AGE_L = 4;

    logic         CLK;
    logic         RESET;
    logic         FREEZE;
    logic         FLUSH;
    logic         IQ_empty;
    logic         IQ_headRdy;
    logic [W-1:0] IQ_popData;
    logic         IQ_pop;
    logic         LSQ_empty;
    logic         LSQ_headRdy;
    logic [W-1:0] LSQ_popData;
    logic         LSQ_pop;
    logic [W-1:0] IQLSQ_popData_OUT;
    logic         Valid_Instruction_OUT;
    logic         Mem_Instruction_OUT;

    int n_cmp = 0;
    int n_err = 0;

    rf_issue_arbiter #(.RENISS_WIDTH(W), .AGE_LIMIT(AGE_L)) dut (
        .CLK                   (CLK),
        .RESET                 (RESET),
        .FREEZE                (FREEZE),
        .FLUSH                 (FLUSH),
        .IQ_empty              (IQ_empty),
        .IQ_headRdy            (IQ_headRdy),
        .IQ_popData            (IQ_popData),
        .IQ_pop                (IQ_pop),
        .LSQ_empty             (LSQ_empty),
        .LSQ_headRdy           (LSQ_headRdy),
        .LSQ_popData           (LSQ_popData),
        .LSQ_pop               (LSQ_pop),
        .IQLSQ_popData_OUT     (IQLSQ_popData_OUT),
        .Valid_Instruction_OUT (Valid_Instruction_OUT),
        .Mem_Instruction_OUT   (Mem_Instruction_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic drive(input logic fz, input logic fl, input logic ie, input logic ir,
                         input logic le, input logic lr,
                         input logic [W-1:0] iqd, input logic [W-1:0] lsqd);
        FREEZE      = fz;
        FLUSH       = fl;
        IQ_empty    = ie;
        IQ_headRdy  = ir;
        LSQ_empty   = le;
        LSQ_headRdy = lr;
        IQ_popData  = iqd;
        LSQ_popData = lsqd;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        drive(0, 0, 1, 0, 1, 0, '0, '0);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    typedef struct {
        logic fz, fl, ie, ir, le, lr;
        logic exp_iq_pop, exp_lsq_pop;
        logic exp_valid, exp_mem;
        int   src;                     // 0 none, 1 IQ data, 2 LSQ data
    } vec_t;

    vec_t vecs[10];

    // Reference model state (rule level)
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_mem;
    int           m_losses;

    initial begin
        logic [W-1:0] iqd, lsqd, d_last;
        logic         e_i, e_l, allowed, force_l, lsq_win, iq_win;

        RESET = 1'b0;
        drive(0, 0, 1, 0, 1, 0, '0, '0);
        #1;
        check("reset_iq_pop", W'(IQ_pop), W'(0));
        check("reset_lsq_pop", W'(LSQ_pop), W'(0));
        check("reset_valid", W'(Valid_Instruction_OUT), W'(0));
        check("reset_mem", W'(Mem_Instruction_OUT), W'(0));
        check("reset_data", IQLSQ_popData_OUT, '0);
        @(negedge CLK);
        RESET = 1'b1;

        //            fz fl ie ir le lr  iqp lsqp val mem src
        vecs[0] = '{0, 0, 0, 1, 0, 1,  1,  0,   1,  0,  1};
        vecs[1] = '{0, 0, 0, 1, 0, 0,  1,  0,   1,  0,  1};
        vecs[2] = '{0, 0, 1, 1, 0, 1,  0,  1,   1,  1,  2};
        vecs[3] = '{0, 0, 0, 0, 0, 1,  0,  1,   1,  1,  2};
        vecs[4] = '{0, 0, 1, 1, 1, 1,  0,  0,   0,  0,  0};
        vecs[5] = '{0, 0, 0, 0, 1, 0,  0,  0,   0,  0,  0};
        vecs[6] = '{1, 0, 0, 1, 0, 1,  0,  0,   0,  0,  0};
        vecs[7] = '{0, 1, 0, 1, 0, 1,  0,  0,   0,  0,  0};
        vecs[8] = '{1, 1, 0, 1, 0, 1,  0,  0,   0,  0,  0};
        vecs[9] = '{0, 0, 1, 0, 0, 1,  0,  1,   1,  1,  2};

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            drive(0, 1, 1, 0, 1, 0, '0, '0);
            @(negedge CLK);
            iqd  = (i == 0) ? W'(12'h0AA) : rnd_data();
            lsqd = (i == 0) ? W'(12'h155) : rnd_data();
            drive(vecs[i].fz, vecs[i].fl, vecs[i].ie, vecs[i].ir, vecs[i].le, vecs[i].lr, iqd, lsqd);
            #1;
            check($sformatf("vec%0d_iq_pop", i), W'(IQ_pop), W'(vecs[i].exp_iq_pop));
            check($sformatf("vec%0d_lsq_pop", i), W'(LSQ_pop), W'(vecs[i].exp_lsq_pop));
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_valid", i), W'(Valid_Instruction_OUT), W'(vecs[i].exp_valid));
            check($sformatf("vec%0d_mem", i), W'(Mem_Instruction_OUT), W'(vecs[i].exp_mem));
            if (vecs[i].src == 1) check($sformatf("vec%0d_data", i), IQLSQ_popData_OUT, iqd);
            if (vecs[i].src == 2) check($sformatf("vec%0d_data", i), IQLSQ_popData_OUT, lsqd);
        end

        // Freeze for three cycles mid-stream, then freeze+flush together
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            d_last = rnd_data();
            drive(0, 0, 0, 1, 1, 0, d_last, '0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            drive(1, 0, 0, 1, 0, 1, rnd_data(), rnd_data());
            #1;
            check("frz_iq_pop", W'(IQ_pop), W'(0));
            check("frz_lsq_pop", W'(LSQ_pop), W'(0));
            @(posedge CLK);
            #1;
            check("frz_valid", W'(Valid_Instruction_OUT), W'(1));
            check("frz_mem", W'(Mem_Instruction_OUT), W'(0));
            check("frz_data", IQLSQ_popData_OUT, d_last);
        end
        @(negedge CLK);
        drive(1, 1, 0, 1, 0, 1, rnd_data(), rnd_data());
        #1;
        check("frzfl_iq_pop", W'(IQ_pop), W'(0));
        check("frzfl_lsq_pop", W'(LSQ_pop), W'(0));
        @(posedge CLK);
        #1;
        check("frzfl_valid", W'(Valid_Instruction_OUT), W'(0));
        check("frzfl_data", IQLSQ_popData_OUT, d_last);

        // Both queues eligible continuously: grant pattern
        do_reset();
        for (int k = 0; k < 12; k++) begin
            logic exp_l;
`ifdef ARB_AGE_LIMIT_EN
            exp_l = ((k % (AGE_L + 1)) == AGE_L);
`else
            exp_l = 1'b0;
`endif
            @(negedge CLK);
            drive(0, 0, 0, 1, 0, 1, rnd_data(), rnd_data());
            #1;
            check($sformatf("pat%0d_iq_pop", k), W'(IQ_pop), W'(!exp_l));
            check($sformatf("pat%0d_lsq_pop", k), W'(LSQ_pop), W'(exp_l));
            @(posedge CLK);
            #1;
            check($sformatf("pat%0d_mem", k), W'(Mem_Instruction_OUT), W'(exp_l));
        end

        // Asynchronous reset mid-cycle while an instruction is valid
        @(negedge CLK);
        drive(0, 0, 0, 1, 0, 1, rnd_data(), rnd_data());
        @(posedge CLK);
        #3;
        check("arst_pre_valid", W'(Valid_Instruction_OUT), W'(1));
        RESET = 1'b0;
        #1;
        check("arst_valid", W'(Valid_Instruction_OUT), W'(0));
        check("arst_mem", W'(Mem_Instruction_OUT), W'(0));
        check("arst_data", IQLSQ_popData_OUT, '0);
        check("arst_iq_pop", W'(IQ_pop), W'(0));
        check("arst_lsq_pop", W'(LSQ_pop), W'(0));
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("arst_first_iq_pop", W'(IQ_pop), W'(1));
        check("arst_first_lsq_pop", W'(LSQ_pop), W'(0));

        // Randomized traffic against the reference model
        do_reset();
        m_data = '0; m_valid = 1'b0; m_mem = 1'b0; m_losses = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
                  rnd_data(), rnd_data());
            e_i     = !IQ_empty && IQ_headRdy;
            e_l     = !LSQ_empty && LSQ_headRdy;
            allowed = !FREEZE && !FLUSH;
`ifdef ARB_AGE_LIMIT_EN
            force_l = (m_losses >= AGE_L) && e_l;
`else
            force_l = 1'b0;
`endif
            lsq_win = e_l && (!e_i || force_l);
            iq_win  = e_i && !lsq_win;
            #1;
            check("rnd_iq_pop", W'(IQ_pop), W'(allowed && iq_win));
            check("rnd_lsq_pop", W'(LSQ_pop), W'(allowed && lsq_win));
            if (FLUSH) begin
                m_valid = 1'b0; m_mem = 1'b0; m_losses = 0;
            end else if (!FREEZE) begin
                if (iq_win) begin
                    m_data = IQ_popData; m_valid = 1'b1; m_mem = 1'b0;
                    if (e_l && m_losses < AGE_L) m_losses++;
                end else if (lsq_win) begin
                    m_data = LSQ_popData; m_valid = 1'b1; m_mem = 1'b1; m_losses = 0;
                end else begin
                    m_valid = 1'b0; m_mem = 1'b0;
                end
            end
            @(posedge CLK);
            #1;
            check("rnd_valid", W'(Valid_Instruction_OUT), W'(m_valid));
            check("rnd_mem", W'(Mem_Instruction_OUT), W'(m_mem));
            check("rnd_data", IQLSQ_popData_OUT, m_data);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_issue_arbiter.md
RF_ISSUE_ARBITER -- requirements
Module: rf_issue_arbiter

Interface
REQ-001 Parameter RENISS_WIDTH, default 137: width of one popped issue-queue/LSQ entry.
REQ-002 Parameter AGE_LIMIT, default 4 (range 1..15): consecutive LSQ losses before a forced LSQ grant.
REQ-003 Port CLK  in  1: single clock; all state changes on the rising edge.
REQ-004 Port RESET  in  1: reset, asynchronous, active-low.
REQ-005 Port FREEZE  in  1: pipeline stall; no pops, all registers hold.
REQ-006 Port FLUSH  in  1: squash; no pops, output valid cleared.
REQ-007 Port IQ_empty  in  1: issue queue has no entry.
REQ-008 Port IQ_headRdy  in  1: IQ head entry has all sources ready.
REQ-009 Port IQ_popData  in  RENISS_WIDTH: IQ head entry.
REQ-010 Port IQ_pop  out  1: dequeue strobe to the IQ.
REQ-011 Port LSQ_empty  in  1: LSQ has no entry.
REQ-012 Port LSQ_headRdy  in  1: LSQ head entry ready.
REQ-013 Port LSQ_popData  in  RENISS_WIDTH: LSQ head entry.
REQ-014 Port LSQ_pop  out  1: dequeue strobe to the LSQ.
REQ-015 Port IQLSQ_popData_OUT  out  RENISS_WIDTH: registered granted entry, to the register-file stage.
REQ-016 Port Valid_Instruction_OUT  out  1: IQLSQ_popData_OUT holds a valid instruction.
REQ-017 Port Mem_Instruction_OUT  out  1: the entry came from the LSQ.

Function
REQ-018 eligIQ = !IQ_empty && IQ_headRdy; eligLSQ = !LSQ_empty && LSQ_headRdy; a pop is enabled only when FREEZE=0 and FLUSH=0.
REQ-019 IQ_pop and LSQ_pop are combinational, mutually exclusive, and never asserted for an empty queue.
REQ-020 Baseline grant: IQ has fixed priority; LSQ wins only when eligLSQ && !eligIQ.
REQ-021 On a grant, the same edge loads the selected popData into IQLSQ_popData_OUT.
REQ-022 On a grant, the same edge sets Valid_Instruction_OUT=1 and sets Mem_Instruction_OUT=1 for an LSQ grant or 0 for an IQ grant.
REQ-023 Latency: the entry popped at edge N is presented from edge N to edge N+1; back-to-back grants give one instruction per cycle.
REQ-024 No grant, with FREEZE=0 and FLUSH=0 (both queues ineligible): Valid_Instruction_OUT<=0, Mem_Instruction_OUT<=0, data holds.
REQ-025 FREEZE=1, FLUSH=0: both pops 0; every register (including Valid) holds.
REQ-026 FLUSH=1: both pops 0; Valid_Instruction_OUT<=0 and Mem_Instruction_OUT<=0; data holds.
REQ-027 FLUSH takes precedence over FREEZE when both are asserted.

Reset
REQ-028 RESET=0 asynchronously clears IQLSQ_popData_OUT, Valid_Instruction_OUT, Mem_Instruction_OUT and the age counter to 0.
REQ-029 IQ_pop and LSQ_pop are 0 for as long as RESET=0.
REQ-030 Reset asserted mid-stream discards the registered instruction; the first grant after deassertion follows REQ-020 from a zero age count.

Configuration
REQ-031 Macro ARB_AGE_LIMIT_EN compiles in LSQ anti-starvation; without it, arbitration is exactly REQ-020 and no age counter exists.
REQ-032 With ARB_AGE_LIMIT_EN, a 4-bit age counter increments, saturating at AGE_LIMIT, on each IQ grant while eligLSQ=1.
REQ-033 The age counter clears on an LSQ grant and on FLUSH, and otherwise holds, including while FREEZE=1.
REQ-034 With ARB_AGE_LIMIT_EN, when age==AGE_LIMIT and eligLSQ=1, LSQ is granted even if eligIQ=1.

Verification
REQ-035 Reset then both queues eligible with distinct data (IQ=0x0AA, LSQ=0x155) -> IQ_pop=1 and LSQ_pop=0; next cycle OUT=0x0AA, Valid=1, Mem=0.
REQ-036 Only LSQ eligible, IQ_empty=1 with IQ_headRdy=1 -> LSQ_pop=1 and IQ_pop=0; next cycle Mem=1, Valid=1.
REQ-037 FREEZE high for 3 cycles during streaming -> pops 0 and outputs frozen; then FREEZE and FLUSH high together -> Valid=0 after the edge, no pop.
REQ-038 ARB_AGE_LIMIT_EN, AGE_LIMIT=4, both eligible continuously -> pattern IQ,IQ,IQ,IQ,LSQ repeating.
REQ-039 Same stimulus without the macro -> IQ every cycle and LSQ_pop never asserted.
REQ-040 RESET pulsed low mid-cycle while Valid=1 -> Valid, Mem and OUT read 0 immediately, before the next clock edge.
